// File: rtl/mii_rx_assembler_pkg.sv
// Shared definitions for the MII receive nibble-to-byte assembler.
package mii_rx_assembler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DROP = 2'd3
    } state_e;

    localparam int NIB_W         = 4;
    localparam int MAX_BYTES_DEF = 1530;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; a clear request takes priority over an increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // count up, holding at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (inc && (count_r != {W{1'b1}})) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/mii_rx_assembler.sv
// Pairs MII receive nibbles (low first) into bytes, flags faulty frames and
// keeps saturating good/bad frame statistics.
module mii_rx_assembler
    import mii_rx_assembler_pkg::*;
#(
    parameter int MAX_BYTES = MAX_BYTES_DEF,
    parameter int LEN_W     = 11,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NIB_W-1:0] mii_rxd,
    input  logic             mii_rx_dv,
    input  logic             mii_rx_er,
    input  logic             stat_clr,
    output logic [7:0]       rx_byte,
    output logic             rx_byte_valid,
    output logic             rx_frame_end,
    output logic             rx_frame_bad,
    output logic [LEN_W-1:0] rx_byte_count,
    output logic [CNT_W-1:0] good_frames,
    output logic [CNT_W-1:0] bad_frames
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

    state_e             state_r;
    logic [NIB_W-1:0]   low_nib_r;
    logic               bad_r;
    logic               suppress_r;
    logic [7:0]         byte_r;
    logic               byte_valid_r;
    logic               frame_end_r;
    logic               frame_bad_r;
    logic [LEN_W-1:0]   count_r;
    logic               end_s;
    logic               end_bad_s;
    logic               inc_good_s;
    logic               inc_bad_s;

    // end-of-frame detect; drives the end pulse and the statistics in the same edge
    always_comb begin
        end_s     = 1'b0;
        end_bad_s = bad_r;
        case (state_r)
            ST_LOW: begin
                if (!mii_rx_dv) begin
                    end_s = 1'b1;
                end else begin
                    end_s = 1'b0;
                end
            end
            ST_HIGH: begin
                if (!mii_rx_dv) begin
                    end_s     = 1'b1;
                    end_bad_s = 1'b1;
                end else begin
                    end_s = 1'b0;
                end
            end
            ST_DROP: begin
                // the drop entered right after reset is not a real frame
                if (!mii_rx_dv) begin
                    end_s = !suppress_r;
                end else begin
                    end_s = 1'b0;
                end
            end
            default: begin
                end_s = 1'b0;
            end
        endcase
    end

    assign inc_good_s = end_s & ~end_bad_s;
    assign inc_bad_s  = end_s &  end_bad_s;

    // receive state machine with registered byte/strobe/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            low_nib_r    <= '0;
            bad_r        <= 1'b0;
            suppress_r   <= 1'b1;
            byte_r       <= 8'h00;
            byte_valid_r <= 1'b0;
            frame_end_r  <= 1'b0;
            frame_bad_r  <= 1'b0;
            count_r      <= '0;
        end else begin
            byte_valid_r <= 1'b0;
            frame_end_r  <= end_s;
            frame_bad_r  <= end_s & end_bad_s;
            case (state_r)
                ST_IDLE: begin
                    if (!mii_rx_dv) begin
                        suppress_r <= 1'b0;
                    end else if (suppress_r) begin
                        state_r <= ST_DROP;
                    end else begin
                        count_r   <= '0;
                        low_nib_r <= mii_rxd;
                        bad_r     <= mii_rx_er;
                        state_r   <= mii_rx_er ? ST_DROP : ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (!mii_rx_dv) begin
                        bad_r   <= 1'b1;
                        state_r <= ST_IDLE;
                    end else if (mii_rx_er || (count_r == MAX_LEN)) begin
                        bad_r   <= 1'b1;
                        state_r <= ST_DROP;
                    end else begin
                        byte_r       <= {mii_rxd, low_nib_r};
                        byte_valid_r <= 1'b1;
                        count_r      <= count_r + LEN_W'(1);
                        state_r      <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (!mii_rx_dv) begin
                        state_r <= ST_IDLE;
                    end else if (mii_rx_er) begin
                        bad_r   <= 1'b1;
                        state_r <= ST_DROP;
                    end else begin
                        low_nib_r <= mii_rxd;
                        state_r   <= ST_HIGH;
                    end
                end
                ST_DROP: begin
                    if (!mii_rx_dv) begin
                        suppress_r <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else begin
                        state_r <= ST_DROP;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_good_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_good_s),
        .clr   (stat_clr),
        .count (good_frames)
    );

    sat_counter #(.W(CNT_W)) u_bad_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_bad_s),
        .clr   (stat_clr),
        .count (bad_frames)
    );

    assign rx_byte       = byte_r;
    assign rx_byte_valid = byte_valid_r;
    assign rx_frame_end  = frame_end_r;
    assign rx_frame_bad  = frame_bad_r;
    assign rx_byte_count = count_r;

endmodule

// File: tb/tb_mii_rx_assembler.sv
// Directed bench for mii_rx_assembler with a byte / frame-end scoreboard.
module tb_mii_rx_assembler;

    localparam int MAXB  = 16;
    localparam int LEN_W = 11;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       mii_rxd = 4'h0;
    logic             mii_rx_dv = 1'b0;
    logic             mii_rx_er = 1'b0;
    logic             stat_clr = 1'b0;
    logic [7:0]       rx_byte;
    logic             rx_byte_valid;
    logic             rx_frame_end;
    logic             rx_frame_bad;
    logic [LEN_W-1:0] rx_byte_count;
    logic [CNT_W-1:0] good_frames;
    logic [CNT_W-1:0] bad_frames;

    int vectors = 0;
    int miscompares = 0;
    int exp_good = 0;
    int exp_bad = 0;
    int exp_cnt = 0;

    logic [7:0] exp_q[$];
    logic       end_q[$];
    logic [3:0] tx_q[$];

    mii_rx_assembler #(.MAX_BYTES(MAXB), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mii_rxd       (mii_rxd),
        .mii_rx_dv     (mii_rx_dv),
        .mii_rx_er     (mii_rx_er),
        .stat_clr      (stat_clr),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .rx_frame_end  (rx_frame_end),
        .rx_frame_bad  (rx_frame_bad),
        .rx_byte_count (rx_byte_count),
        .good_frames   (good_frames),
        .bad_frames    (bad_frames)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every strobe must match the head of its expectation queue
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_byte_valid || rx_frame_end)
                check("overlap", 32'(rx_byte_valid & rx_frame_end), 32'd0);
            if (rx_byte_valid) begin
                if (exp_q.size() == 0) check("extra_byte", 32'(rx_byte_valid), 32'd0);
                else check("byte", 32'(rx_byte), 32'(exp_q.pop_front()));
            end
            if (rx_frame_end) begin
                if (end_q.size() == 0) check("extra_end", 32'(rx_frame_end), 32'd0);
                else check("frame_bad", 32'(rx_frame_bad), 32'(end_q.pop_front()));
            end
        end
    end

    task automatic drive(input logic dv, input logic er, input logic [3:0] nib, input logic clr);
        @(posedge clk);
        #1;
        mii_rx_dv = dv;
        mii_rx_er = er;
        mii_rxd   = nib;
        stat_clr  = clr;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic add_byte(input logic [7:0] b);
        tx_q.push_back(b[3:0]);
        tx_q.push_back(b[7:4]);
    endtask

    task automatic add_preamble();
        repeat (7) add_byte(8'h55);
        add_byte(8'hD5);
    endtask

    // sends tx_q as one frame; er_idx marks the nibble carrying rx_er (-1 = none)
    task automatic send_frame(input int er_idx, input logic clr);
        int  cnt;
        bit  bad;
        bit  drop;
        cnt  = 0;
        bad  = 1'b0;
        drop = 1'b0;
        for (int i = 0; i < tx_q.size(); i++) begin
            drive(1'b1, (i == er_idx), tx_q[i], 1'b0);
            if (!drop) begin
                if (i == er_idx) begin
                    bad = 1'b1; drop = 1'b1;
                end else if (i % 2 == 1) begin
                    if (cnt == MAXB) begin
                        bad = 1'b1; drop = 1'b1;
                    end else begin
                        exp_q.push_back({tx_q[i], tx_q[i-1]});
                        cnt++;
                    end
                end
            end
        end
        if (!drop && (tx_q.size() % 2 == 1)) bad = 1'b1;
        drive(1'b0, 1'b0, 4'h0, clr);
        end_q.push_back(bad);
        if (clr) begin
            exp_good = 0; exp_bad = 0;
        end else if (bad) exp_bad++;
        else exp_good++;
        exp_cnt = cnt;
        tx_q.delete();
    endtask

    task automatic check_stats(input string tag);
        idle(2);
        check({tag, "_count"}, 32'(rx_byte_count), 32'(exp_cnt));
        check({tag, "_good"},  32'(good_frames),   32'(exp_good));
        check({tag, "_bad"},   32'(bad_frames),    32'(exp_bad));
    endtask

    initial begin
        #12;
        check("rst_byte",  32'(rx_byte), 32'd0);
        check("rst_valid", 32'(rx_byte_valid), 32'd0);
        check("rst_end",   32'(rx_frame_end), 32'd0);
        check("rst_count", 32'(rx_byte_count), 32'd0);
        check("rst_good",  32'(good_frames), 32'd0);
        check("rst_bad",   32'(bad_frames), 32'd0);
        #5 rst_n = 1'b1;
        idle(3);

        add_preamble(); add_byte(8'h01); add_byte(8'h02); add_byte(8'h03);
        send_frame(-1, 1'b0);
        check_stats("clean");

        add_preamble(); add_byte(8'h01); add_byte(8'h02); add_byte(8'h03);
        tx_q.push_back(4'hA);
        send_frame(-1, 1'b0);
        check_stats("dribble");

        add_preamble(); add_byte(8'h01); add_byte(8'h02); add_byte(8'h03);
        send_frame(9, 1'b0);
        check_stats("rx_er");

        for (int i = 0; i < 20; i++) add_byte(8'(i * 7 + 3));
        send_frame(-1, 1'b0);
        check_stats("oversize");

        add_byte(8'h11); add_byte(8'h22); add_byte(8'h33);
        send_frame(-1, 1'b0);
        add_byte(8'h44); add_byte(8'h55); add_byte(8'h66);
        send_frame(-1, 1'b0);
        check_stats("b2b");
        add_byte(8'h77); add_byte(8'h88); add_byte(8'h99);
        send_frame(-1, 1'b1);
        check_stats("stat_clr");

        // reset in the middle of byte 2
        drive(1'b1, 1'b0, 4'h5, 1'b0);
        drive(1'b1, 1'b0, 4'h5, 1'b0);
        exp_q.push_back(8'h55);
        drive(1'b1, 1'b0, 4'hD, 1'b0);
        drive(1'b1, 1'b0, 4'h5, 1'b0);
        exp_q.push_back(8'h5D);
        drive(1'b1, 1'b0, 4'h1, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_good = 0; exp_bad = 0; exp_cnt = 0;
        check("mid_rst_byte",  32'(rx_byte), 32'd0);
        check("mid_rst_valid", 32'(rx_byte_valid), 32'd0);
        check("mid_rst_count", 32'(rx_byte_count), 32'd0);
        check("mid_rst_good",  32'(good_frames), 32'd0);
        check("mid_rst_bad",   32'(bad_frames), 32'd0);
        drive(1'b1, 1'b0, 4'h7, 1'b0);
        drive(1'b1, 1'b0, 4'h7, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 4'(i), 1'b0);
        idle(3);
        check_stats("post_rst_drop");

        add_preamble(); add_byte(8'hAB);
        send_frame(-1, 1'b0);
        check_stats("post_rst_clean");

        idle(3);
        check("byte_queue_empty", 32'(exp_q.size()), 32'd0);
        check("end_queue_empty",  32'(end_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mii_rx_assembler.md
Name: mii_rx_assembler

Overview:
Front-end stage that directly feeds the receiver's `rx_byte` / `rx_byte_valid` inputs.
- Pairs 4-bit MII receive nibbles (low nibble first) into bytes.
- Passes preamble, SFD, payload and FCS through unchanged, so SFD detection happens downstream.
- Flags per-frame faults: rx_er, odd nibble count (dribble), oversize.
- Keeps saturating good/bad frame statistics.

Parameters:
- MAX_BYTES, 1530: largest legal frame in bytes, counted from the first rx_dv byte (preamble + SFD included).
- LEN_W, 11: width of the byte counter; must hold MAX_BYTES+1.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  single system clock; MII nibble rate, one nibble per cycle when mii_rx_dv=1.
- rst_n  in  1  asynchronous, active-low reset.
- mii_rxd  in  4  receive nibble.
- mii_rx_dv  in  1  receive data valid.
- mii_rx_er  in  1  receive error.
- stat_clr  in  1  synchronous clear of good_frames/bad_frames.
- rx_byte  out  8  assembled byte = {high nibble, low nibble}.
- rx_byte_valid  out  1  one-cycle strobe qualifying rx_byte.
- rx_frame_end  out  1  one-cycle pulse, cycle after mii_rx_dv falls.
- rx_frame_bad  out  1  valid only with rx_frame_end; 1 = rx_er, dribble or oversize occurred.
- rx_byte_count  out  LEN_W  bytes emitted in the current/last frame; held until the next frame starts.
- good_frames  out  CNT_W  saturating count of frames ending with rx_frame_bad=0.
- bad_frames  out  CNT_W  saturating count of frames ending with rx_frame_bad=1.

Behaviour:
- **Reset:** rst_n low asynchronously clears all outputs, counters, the nibble latch and flags, and forces IDLE.
  - Reset mid-frame discards the partial frame with no end pulse.
  - After reset release, the assembler waits for mii_rx_dv=0 before accepting a frame (enter via DROP if mii_rx_dv=1 at release).
- **State encoding:** IDLE, LOW, HIGH, DROP (2 bits).
- **IDLE:**
  - mii_rx_dv=1: latch the nibble as low, clear rx_byte_count and the bad flag, go to HIGH.
  - If mii_rx_er=1 in the same cycle, set the bad flag and go to DROP instead.
- **HIGH:**
  - mii_rx_dv=1, mii_rx_er=0:
    - Register rx_byte={mii_rxd, low latch} and pulse rx_byte_valid on the next cycle; latency is 1 cycle after the high-nibble cycle.
    - Increment rx_byte_count, go to LOW.
  - mii_rx_dv=0: odd nibble (dribble). Discard the latched nibble, set the bad flag, end the frame.
- **LOW:**
  - mii_rx_dv=1: latch the low nibble, go to HIGH.
  - mii_rx_dv=0: clean end of frame.
- **Error during a frame:** mii_rx_er=1 with mii_rx_dv=1 in LOW or HIGH sets the bad flag and goes to DROP. The nibble and any pending partial byte are discarded.
- **Oversize:** completing a byte when rx_byte_count==MAX_BYTES suppresses that byte, sets the bad flag, and goes to DROP. rx_byte_count stays at MAX_BYTES.
- **DROP:** no bytes emitted. Leave only on mii_rx_dv=0, which counts as end of frame.
- **End of frame (any state to IDLE on mii_rx_dv falling):**
  - Next cycle: rx_frame_end=1 and rx_frame_bad=bad flag.
  - The matching counter increments on that same cycle, saturating at all-ones.
  - A frame_end from the post-reset DROP entry is suppressed.
- **Inter-frame gap:** mii_rx_dv may rise again in the cycle immediately after it falls. The new frame starts normally, and the previous frame's end pulse still appears.
- **Strobe overlap:** rx_byte_valid and rx_frame_end never coincide; the last byte strobe precedes the end pulse by at least 1 cycle.
- **stat_clr:**
  - Zeroes both counters on the next edge.
  - If it coincides with an increment, clear wins.
  - rx_byte_count is unaffected.
- **Idle outputs:** rx_byte holds its last value when rx_byte_valid=0.

Decomposition:
- Shared package holds:
  - State encodings: ST_IDLE, ST_LOW, ST_HIGH, ST_DROP.
  - The nibble-width constant (4).
  - Default MAX_BYTES.
- One natural sub-module, `sat_counter` (parameter W; inputs inc, clr; output count), instantiated twice for good_frames and bad_frames.
- Everything else stays flat.

Test Plan:
1. **Clean frame:** 7 bytes 0x55 plus 0xD5 then 0x01,0x02,0x03 sent as 14+8 nibbles low-first → 11 rx_byte_valid strobes with exact bytes, rx_frame_end with rx_frame_bad=0, rx_byte_count=11, good_frames=1.
2. **Dribble:** same frame plus one extra nibble 0xA before mii_rx_dv falls → 11 bytes, no 12th, rx_frame_bad=1, bad_frames=1.
3. **rx_er mid-frame:** mii_rx_er=1 on nibble 10 → only 4 bytes emitted (preamble bytes 0–3; the byte containing nibble 10 is dropped), bad frame counted at mii_rx_dv fall, good_frames unchanged.
4. **Oversize with MAX_BYTES=16:** 20-byte frame → exactly 16 strobes, rx_byte_count=16, rx_frame_bad=1.
5. **Back-to-back frames:** mii_rx_dv low for 1 cycle between two 3-byte frames → two end pulses, 6 bytes total, good_frames=2. Then stat_clr together with a third frame end → counters read 0.
6. **Reset mid-frame:** rst_n low during byte 2 → outputs zero immediately. Release with mii_rx_dv=1: no bytes and no end pulse until mii_rx_dv drops; the next frame is received cleanly.
